// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that muxes N_REQ valid/data requesters into a single
// one-entry output register with a valid/ready handshake.
module rr_mux_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int SRC_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SRC_W-1:0]       out_src,
  input  logic                   out_ready
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;

  logic             any_req;
  logic             load;
  logic             hi_found;
  logic [SRC_W-1:0] hi_idx;
  logic             lo_found;
  logic [SRC_W-1:0] lo_idx;
  logic [SRC_W-1:0] winner;
  logic [WIDTH-1:0] sel_data;

  assign any_req = |req_valid;
  // Gated by rst_n so no handshake can complete while reset is held.
  assign load    = rst_n && ((state_q == ST_EMPTY) || out_ready);

  // Wrapped scan: the first valid at or above the pointer wins; otherwise the
  // lowest valid index wins.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && !hi_found && (SRC_W'(i) >= ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = SRC_W'(i);
      end
      if (req_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = SRC_W'(i);
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

  // Only the winner's lane reaches sel_data, so X on other lanes is blocked.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner == SRC_W'(i)) begin
        sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    src_d     = src_q;
    ptr_d     = ptr_q;
    req_ready = '0;
    if (load) begin
      if (any_req) begin
        state_d = ST_FULL;
        data_d  = sel_data;
        src_d   = winner;
        ptr_d   = (winner == SRC_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        for (int unsigned i = 0; i < N_REQ; i++) begin
          req_ready[i] = (winner == SRC_W'(i));
        end
      end else begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomized and directed checks of rr_mux_arbiter against a modulo-scan
// round-robin model held in the bench.
module tb_rr_mux_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_src;
  logic            out_ready;

  rr_mux_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: output register contents and round-robin pointer.
  int m_valid, m_data, m_src, m_ptr;
  logic [W-1:0] dval [N];
  bit use_x;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0;
  endtask

  // One cycle: drive at negedge, compare against the model, advance the model
  // at the following posedge, return just after that edge.
  task automatic step(input logic [N-1:0] v, input logic r);
    int w;
    bit any, ld;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    req_valid = v;
    out_ready = r;
    w = 0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (!any && v[idx]) begin
        any = 1'b1;
        w = idx;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (use_x && (!any || i != w) && ($urandom_range(1) == 1))
        req_data[i*W +: W] = 'x;
      else
        req_data[i*W +: W] = dval[i];
    end
    #1;
    ld = rst_n && (m_valid == 0 || r);
    exp_rdy = (ld && any) ? (N'(1) << w) : '0;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("out_src",   32'(out_src),   32'(m_src));
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (ld && any) begin
      m_valid = 1;
      m_data  = int'(dval[w]);
      m_src   = w;
      m_ptr   = (w + 1) % N;
    end else if (ld) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_dir_data();
    for (int i = 0; i < N; i++) dval[i] = W'(8'hA0 + i);
  endtask

  initial begin
    use_x     = 1'b0;
    rst_n     = 1'b0;
    req_valid = '1;
    out_ready = 1'b0;
    req_data  = '0;
    set_dir_data();
    model_reset();

    // Reset then idle
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    step(4'b0000, 1'b1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_out_src",   32'(out_src),   32'd0);

    // Round-robin rotation
    for (int k = 0; k < 6; k++) begin
      step(4'b1111, 1'b1);
      chk("rot_src",  32'(out_src),  32'(k % 4));
      chk("rot_data", 32'(out_data), 32'(8'hA0 + (k % 4)));
    end

    // Backpressure
    do_reset();
    step(4'b0101, 1'b1);
    chk("bp_first_src", 32'(out_src), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(4'b0101, 1'b0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_src",   32'(out_src),   32'd0);
      chk("bp_data",  32'(out_data),  32'hA0);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    step(4'b0101, 1'b1);
    chk("bp_refill_src", 32'(out_src), 32'd2);

    // Sparse requests, pointer holds over idle cycles
    do_reset();
    step(4'b0010, 1'b1);
    chk("sp_src1", 32'(out_src), 32'd1);
    step(4'b0000, 1'b1);
    chk("sp_idle_valid", 32'(out_valid), 32'd0);
    step(4'b0000, 1'b1);
    step(4'b0011, 1'b1);
    chk("sp_wrap_src0", 32'(out_src), 32'd0);

    // Single requester at top index, then wrap to 0
    for (int k = 0; k < 3; k++) begin
      step(4'b1000, 1'b1);
      chk("single_src3", 32'(out_src), 32'd3);
    end
    step(4'b1001, 1'b1);
    chk("wrap_src0", 32'(out_src), 32'd0);

    // Asynchronous reset while holding a word under backpressure
    step(4'b0010, 1'b1);
    step(4'b0010, 1'b0);
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_async_valid", 32'(out_valid), 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    step(4'b1111, 1'b1);
    chk("ar_after_src", 32'(out_src), 32'd0);

    // Randomized traffic with X on non-winning lanes
    use_x = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) dval[i] = W'($urandom);
      step(N'($urandom), ($urandom_range(9) < 7));
    end
    use_x = 1'b0;
    step(4'b0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one output channel between N_REQ requesters.
- Each requester presents a valid/data pair. The block computes the mux select, grants one requester per cycle, and captures the selected word into a one-entry output register with valid/ready handshake.
- It sits in front of any shared downstream consumer and replaces fixed-priority muxing with fair, backpressure-aware scheduling.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..16, not required to be a power of two.
- WIDTH, 8, data width per requester in bits.
- SRC_W, $clog2(N_REQ), width of the source index. Derived; not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  bit i high means requester i offers a word.
- req_data  input  N_REQ*WIDTH  requester i data occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  N_REQ  one-hot or zero; bit i high means requester i's word is taken this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_src  output  SRC_W  index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - out_valid=0, out_data=0, out_src=0, rr_ptr=0.
  - req_ready is combinational and reads 0 while out_valid=0 and no req_valid is high.
- Reset mid-operation discards the held word. No handshake completes on the reset edge.
- Internal state:
  - rr_ptr[SRC_W-1:0] is the highest-priority index for the next arbitration.
  - out_valid doubles as the FULL/EMPTY state of the output register: EMPTY when 0, FULL when 1.
- Load enable: load = !out_valid || out_ready. The register can take a word when empty or when it is being drained in the same cycle.
- Arbitration (combinational, every cycle):
  - winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping N_REQ-1 -> 0.
  - any_req = |req_valid.
- Handshake:
  - req_ready[winner] = load && any_req; all other bits are 0.
  - req_ready never depends on req_data.
  - A requester's word transfers on any edge where req_valid[i] && req_ready[i].
- On a clock edge:
  - If load && any_req: out_data<=req_data[winner], out_src<=winner, out_valid<=1, rr_ptr<=(winner==N_REQ-1)?0:winner+1.
  - Else if load && !any_req: out_valid<=0. out_data, out_src and rr_ptr hold.
  - Else (FULL, out_ready=0): all state holds, and out_data/out_src stay stable until accepted.
- Latency and throughput:
  - Latency is 1 cycle from request handshake to out_valid.
  - Sustained throughput is 1 word/cycle when out_ready=1.
- Fairness: a continuously requesting source waits at most N_REQ-1 grants between its own grants.
- rr_ptr advances only on a grant. Idle cycles and backpressure cycles do not rotate priority.
- Simultaneous drain and refill: when FULL and out_ready=1 with any_req, the old word leaves and the new word loads on the same edge. There is no bubble.
- Wrap-around: after a grant to N_REQ-1, rr_ptr=0. For a non-power-of-two N_REQ, rr_ptr never takes values >= N_REQ.
- A requester deasserting req_valid without a handshake is legal. The arbiter simply re-evaluates the winner next cycle.
- X on req_data of non-winning requesters must not propagate to the outputs.

Test Plan:
1. Reset then idle: rst_n low for 2 cycles with req_valid=4'b1111. Expect out_valid=0 and req_ready=0 throughout reset. After release with req_valid=0: out_valid=0, out_src=0.
2. Round-robin rotation: N_REQ=4, req_valid=4'b1111 held, data[i]=8'hA0+i, out_ready=1. Expect out_src sequence 0,1,2,3,0,1, with out_data A0,A1,A2,A3,A0,A1 and one word per cycle from the second cycle.
3. Backpressure: req_valid=4'b0101, out_ready=0 for 3 cycles after the first load. Expect out_valid=1, out_src=0, out_data stable, req_ready=0 for all 3 cycles. When out_ready=1, the same edge loads src 2.
4. Sparse requests and pointer hold: grant src 1, then 2 idle cycles (req_valid=0), then req_valid=4'b0011. Expect next winner src 0: pointer=2 wraps past empty slots 2,3. The idle cycles must not move the pointer.
5. Wrap and single requester: only req_valid[3]=1 for 3 cycles. Expect src 3 granted every cycle, rr_ptr=0 after each grant, and no starvation of 3.
6. Async reset mid-transfer: while out_valid=1 and out_ready=0, pulse rst_n low between clock edges. Expect out_valid=0 immediately, without waiting for clk. Next arbitration after release starts from src 0.
